// File: rtl/dmx_universe_ctrl_if.sv
// Slot-write handshakes from the two channel-data producers (host and effects engine).
// The producer side uses master; the universe controller uses slave.
interface dmx_universe_ctrl_if;
  logic       h_valid;
  logic       h_ready;
  logic [8:0] h_addr;
  logic [7:0] h_data;
  logic       f_valid;
  logic       f_ready;
  logic [8:0] f_addr;
  logic [7:0] f_data;

  modport master (
    output h_valid, h_addr, h_data, f_valid, f_addr, f_data,
    input  h_ready, f_ready
  );

  modport slave (
    input  h_valid, h_addr, h_data, f_valid, f_addr, f_data,
    output h_ready, f_ready
  );
endinterface

// File: rtl/dmx_universe_ctrl.sv
// DMX512 universe frame scheduler: round-robin slot-write arbitration into the shadow bank,
// refresh-rate pacing of transmitter frames and atomic bank swap between frames.
module dmx_universe_ctrl #(
  parameter int unsigned CLK_FREQ  = 12090000,
  parameter int unsigned MAX_SLOTS = 512
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_i,
  input  logic [1:0]         period_sel_i,
  input  logic [9:0]         num_slots_i,
  dmx_universe_ctrl_if.slave prod_if,
  input  logic               commit_req_i,
  output logic               commit_ack_o,
  output logic               wr_en_o,
  output logic               wr_bank_o,
  output logic [8:0]         wr_addr_o,
  output logic [7:0]         wr_data_o,
  output logic               rd_bank_o,
  output logic               tx_start_o,
  input  logic               tx_busy_i,
  output logic [9:0]         tx_num_bytes_o,
  output logic               overrun_o,
  output logic               tx_fault_o,
  output logic [15:0]        frame_count_o
);

  localparam logic [23:0] Per10Hz  = 24'(CLK_FREQ / 10);
  localparam logic [23:0] Per20Hz  = 24'(CLK_FREQ / 20);
  localparam logic [23:0] Per30Hz  = 24'(CLK_FREQ / 30);
  localparam logic [23:0] Per40Hz  = 24'(CLK_FREQ / 40);
  localparam logic [9:0]  MaxSlots = 10'(MAX_SLOTS);

  typedef enum logic [2:0] {
    StIdle, StStart, StAckWait, StBusy, StDone, StSwap, StWait
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [3:0]  ack_cnt_q, ack_cnt_d;
  logic        pending_q, pending_d;
  logic        prio_fx_q, prio_fx_d;
  logic        ovr_seen_q, ovr_seen_d;
  logic        rd_bank_q, rd_bank_d;
  logic [9:0]  nbytes_q, nbytes_d;
  logic [15:0] frame_q, frame_d;
  logic        fault_q, fault_d;
  logic        wr_en_q, wr_bank_q;
  logic [8:0]  wr_addr_q;
  logic [7:0]  wr_data_q;

  logic [23:0] period_n;
  logic        h_grant, f_grant, xfer, commit_any;
  logic        tx_start, commit_ack, overrun;

  always_comb begin
    unique case (period_sel_i)
      2'b00: period_n = Per10Hz;
      2'b01: period_n = Per20Hz;
      2'b10: period_n = Per30Hz;
      2'b11: period_n = Per40Hz;
    endcase
  end

  // Ready depends on valid so that at most one producer ever sees ready.
  assign h_grant = (state_q != StSwap) && prod_if.h_valid && (!prod_if.f_valid || !prio_fx_q);
  assign f_grant = (state_q != StSwap) && prod_if.f_valid && (!prod_if.h_valid || prio_fx_q);
  assign xfer    = h_grant || f_grant;
  assign prod_if.h_ready = h_grant;
  assign prod_if.f_ready = f_grant;

  assign prio_fx_d  = h_grant ? 1'b1 : (f_grant ? 1'b0 : prio_fx_q);
  assign commit_any = pending_q || commit_req_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ack_cnt_d  = ack_cnt_q;
    pending_d  = commit_any;
    ovr_seen_d = ovr_seen_q;
    rd_bank_d  = rd_bank_q;
    nbytes_d   = nbytes_q;
    frame_d    = frame_q;
    fault_d    = 1'b0;
    tx_start   = 1'b0;
    commit_ack = 1'b0;
    overrun    = 1'b0;

    if (state_q != StIdle) begin
      cnt_d = (cnt_q >= period_n) ? period_n : cnt_q + 24'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (enable_i)        state_d = StStart;
        else if (commit_any) state_d = StSwap;
      end
      StStart: begin
        tx_start   = 1'b1;
        frame_d    = frame_q + 16'd1;
        // The tx_start cycle is cycle 0 of the period, so start-to-start spacing is PERIOD_N.
        cnt_d      = 24'd1;
        ack_cnt_d  = 4'd0;
        ovr_seen_d = 1'b0;
        if (num_slots_i == 10'd0)         nbytes_d = 10'd1;
        else if (num_slots_i > MaxSlots)  nbytes_d = MaxSlots;
        else                              nbytes_d = num_slots_i;
        state_d    = StAckWait;
      end
      StAckWait: begin
        if (tx_busy_i) begin
          state_d = StBusy;
        end else if (ack_cnt_q == 4'd15) begin
          fault_d = 1'b1;
          state_d = StDone;
        end else begin
          ack_cnt_d = ack_cnt_q + 4'd1;
        end
      end
      StBusy: begin
        if (cnt_q >= period_n && !ovr_seen_q) begin
          overrun    = 1'b1;
          ovr_seen_d = 1'b1;
        end
        if (!tx_busy_i) state_d = StDone;
      end
      StDone: begin
        if (commit_any)     state_d = StSwap;
        else if (!enable_i) state_d = StIdle;
        else                state_d = StWait;
      end
      StSwap: begin
        rd_bank_d  = ~rd_bank_q;
        commit_ack = 1'b1;
        pending_d  = 1'b0;
        state_d    = enable_i ? StWait : StIdle;
      end
      StWait: begin
        if (!enable_i)                       state_d = StIdle;
        else if (cnt_q >= period_n - 24'd1)  state_d = StStart;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ack_cnt_q  <= '0;
      pending_q  <= 1'b0;
      prio_fx_q  <= 1'b0;
      ovr_seen_q <= 1'b0;
      rd_bank_q  <= 1'b0;
      nbytes_q   <= '0;
      frame_q    <= '0;
      fault_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_bank_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ack_cnt_q  <= ack_cnt_d;
      pending_q  <= pending_d;
      prio_fx_q  <= prio_fx_d;
      ovr_seen_q <= ovr_seen_d;
      rd_bank_q  <= rd_bank_d;
      nbytes_q   <= nbytes_d;
      frame_q    <= frame_d;
      fault_q    <= fault_d;
      wr_en_q    <= xfer;
      if (xfer) begin
        wr_bank_q <= ~rd_bank_q;
        wr_addr_q <= h_grant ? prod_if.h_addr : prod_if.f_addr;
        wr_data_q <= h_grant ? prod_if.h_data : prod_if.f_data;
      end
    end
  end

  assign commit_ack_o   = commit_ack;
  assign wr_en_o        = wr_en_q;
  assign wr_bank_o      = wr_bank_q;
  assign wr_addr_o      = wr_addr_q;
  assign wr_data_o      = wr_data_q;
  assign rd_bank_o      = rd_bank_q;
  assign tx_start_o     = tx_start;
  assign tx_num_bytes_o = nbytes_q;
  assign overrun_o      = overrun;
  assign tx_fault_o     = fault_q;
  assign frame_count_o  = frame_q;

endmodule

// File: tb/tb_dmx_universe_ctrl.sv
// Self-checking bench for dmx_universe_ctrl: write-port scoreboard, grant-order table,
// slot-count table and hand-written sequences for commit, overrun, fault and reset.
module tb_dmx_universe_ctrl;
  localparam int unsigned ClkFreq = 12000;
  localparam int          Period  = 300;  // period_sel = 11 at ClkFreq

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  period_sel;
  logic [9:0]  num_slots;
  logic        commit_req;
  logic        tx_busy = 1'b0;
  logic        commit_ack_o, wr_en_o, wr_bank_o, rd_bank_o, tx_start_o;
  logic        overrun_o, tx_fault_o;
  logic [8:0]  wr_addr_o;
  logic [7:0]  wr_data_o;
  logic [9:0]  tx_num_bytes_o;
  logic [15:0] frame_count_o;

  dmx_universe_ctrl_if pif ();

  dmx_universe_ctrl #(.CLK_FREQ(ClkFreq), .MAX_SLOTS(512)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable_i       (enable),
    .period_sel_i   (period_sel),
    .num_slots_i    (num_slots),
    .prod_if        (pif),
    .commit_req_i   (commit_req),
    .commit_ack_o   (commit_ack_o),
    .wr_en_o        (wr_en_o),
    .wr_bank_o      (wr_bank_o),
    .wr_addr_o      (wr_addr_o),
    .wr_data_o      (wr_data_o),
    .rd_bank_o      (rd_bank_o),
    .tx_start_o     (tx_start_o),
    .tx_busy_i      (tx_busy),
    .tx_num_bytes_o (tx_num_bytes_o),
    .overrun_o      (overrun_o),
    .tx_fault_o     (tx_fault_o),
    .frame_count_o  (frame_count_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ack_total = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (commit_ack_o) ack_total++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %s, expected %s", name, act, exp);
    end
  endtask

  // Transmitter model: goes busy in the tx_start cycle for busy_len cycles when tx_on.
  logic tx_on = 1'b1;
  int   busy_len = 100;
  int   busy_cnt = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (!rst_n) busy_cnt = 0;
    else if (tx_on && tx_start_o) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    tx_busy = (busy_cnt > 0);
  end

  // Write-port scoreboard: push on transfer, pop when wr_en shows up one cycle later.
  typedef struct packed {logic bank; logic [8:0] addr; logic [7:0] data;} wr_t;
  wr_t  wr_q[$];
  wr_t  exp_w;
  logic exp_rd_bank = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      wr_q.delete();
    end else begin
      if (wr_en_o) begin
        if (wr_q.size() == 0) begin
          check("wr_unexpected", 64'd1, 64'd0);
        end else begin
          exp_w = wr_q.pop_front();
          check("wr_port", {wr_bank_o, wr_addr_o, wr_data_o}, exp_w);
        end
      end else if (wr_q.size() != 0) begin
        check("wr_latency", 64'd0, 64'd1);
        void'(wr_q.pop_front());
      end
      if (pif.h_ready || pif.f_ready) check("ready_onehot", pif.h_ready & pif.f_ready, 64'd0);
      if (pif.h_valid && pif.h_ready) wr_q.push_back({~exp_rd_bank, pif.h_addr, pif.h_data});
      if (pif.f_valid && pif.f_ready) wr_q.push_back({~exp_rd_bank, pif.f_addr, pif.f_data});
    end
  end

  task automatic wait_start(input int limit, output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (tx_start_o) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
    if (!ok) check("tx_start_timeout", 64'd0, 64'd1);
  endtask

  // Producers hold each item until it transfers; returns the grant order as H/F letters.
  task automatic produce(input int nh, input int nf, input logic [8:0] hbase,
                         input logic [8:0] fbase, output string order);
    int  hi = 0;
    int  fi = 0;
    int  budget = 0;
    bit  hx, fx;
    order = "";
    while ((hi < nh || fi < nf) && budget < 40) begin
      pif.h_valid = (hi < nh);
      pif.h_addr  = hbase + 9'(hi);
      pif.h_data  = 8'h40 + 8'(hi);
      pif.f_valid = (fi < nf);
      pif.f_addr  = fbase + 9'(fi);
      pif.f_data  = 8'hC0 + 8'(fi);
      @(negedge clk);
      hx = pif.h_valid && pif.h_ready;
      fx = pif.f_valid && pif.f_ready;
      @(posedge clk);
      #1;
      if (hx) begin hi++; order = {order, "H"}; end
      if (fx) begin fi++; order = {order, "F"}; end
      budget++;
    end
    pif.h_valid = 1'b0;
    pif.f_valid = 1'b0;
    if (budget >= 40) check("produce_timeout", 64'd0, 64'd1);
  endtask

  typedef struct {int nh; int nf; string order;} gvec_t;
  typedef struct {logic [9:0] ns; logic [9:0] nbytes;} nvec_t;
  gvec_t      gtab[5];
  nvec_t      ntab[7];
  logic [9:0] nb_q[$];

  function automatic logic [63:0] out_vec();
    return {tx_start_o, commit_ack_o, wr_en_o, wr_bank_o, wr_addr_o, wr_data_o, rd_bank_o,
            tx_num_bytes_o, overrun_o, tx_fault_o, frame_count_o, pif.h_ready, pif.f_ready};
  endfunction

  initial begin
    string      order;
    int         t, prev_t, k_ov, n_ov, k_st, k_ft, n_ft, ack0;
    bit         ok;
    logic [9:0] cur;
    logic [15:0] fc_exp;

    gtab[0] = '{2, 2, "HFHF"};
    gtab[1] = '{3, 0, "HHH"};
    gtab[2] = '{1, 1, "FH"};
    gtab[3] = '{0, 2, "FF"};
    gtab[4] = '{2, 1, "HFH"};
    ntab[0] = '{10'd0,    10'd1};
    ntab[1] = '{10'd600,  10'd512};
    ntab[2] = '{10'd1,    10'd1};
    ntab[3] = '{10'd512,  10'd512};
    ntab[4] = '{10'd513,  10'd512};
    ntab[5] = '{10'd1023, 10'd512};
    ntab[6] = '{10'd100,  10'd100};

    rst_n = 1'b0;
    enable = 1'b0; period_sel = 2'b11; num_slots = 10'd10; commit_req = 1'b0;
    pif.h_valid = 1'b0; pif.h_addr = '0; pif.h_data = '0;
    pif.f_valid = 1'b0; pif.f_addr = '0; pif.f_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", out_vec(), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Round-robin grants, writes land in bank 1 while the transmitter reads bank 0.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      produce(gtab[i].nh, gtab[i].nf, 9'h010 + 9'(16 * i), 9'h100 + 9'(16 * i), order);
      check_str($sformatf("grant_order[%0d]", i), order, gtab[i].order);
    end
    repeat (3) @(negedge clk);

    // Slot-count clamping, frame pacing and frame counter.
    @(posedge clk); #1;
    busy_len  = 100;
    num_slots = ntab[0].ns;
    nb_q.push_back(ntab[0].nbytes);
    enable = 1'b1;
    prev_t = 0;
    fc_exp = 16'd0;
    for (int i = 0; i < 7; i++) begin
      wait_start(2 * Period, t, ok);
      if (!ok) break;
      @(negedge clk);
      cur = nb_q.pop_front();
      fc_exp++;
      check($sformatf("tx_num_bytes[%0d]", i), tx_num_bytes_o, cur);
      check($sformatf("frame_count[%0d]", i), frame_count_o, fc_exp);
      if (i > 0) check($sformatf("frame_spacing[%0d]", i), t - prev_t, Period);
      prev_t = t;
      if (i < 6) begin
        @(posedge clk); #1;
        num_slots = ntab[i + 1].ns;
        nb_q.push_back(ntab[i + 1].nbytes);
        repeat (20) @(negedge clk);
        check($sformatf("nbytes_held[%0d]", i), tx_num_bytes_o, cur);
      end
    end

    // Two commit requests during BUSY merge into one swap after the frame.
    busy_len = 40;
    wait_start(2 * Period, t, ok);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 commit_req = 1'b1;
    @(posedge clk); #1 commit_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 commit_req = 1'b1;
    @(posedge clk); #1 commit_req = 1'b0;
    ack0 = ack_total;
    pif.h_valid = 1'b1; pif.h_addr = 9'h1F0; pif.h_data = 8'h5A;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!tx_busy) begin ok = 1'b1; break; end
    end
    if (!ok) check("busy_fall_timeout", 64'd0, 64'd1);
    @(negedge clk);
    check("ack_in_done", commit_ack_o, 64'd0);
    @(negedge clk);
    check("commit_ack", commit_ack_o, 64'd1);
    check("swap_h_ready", pif.h_ready, 64'd0);
    exp_rd_bank = 1'b1;
    @(negedge clk);
    check("ack_single_cycle", commit_ack_o, 64'd0);
    check("rd_bank_swapped", rd_bank_o, 64'd1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 pif.h_valid = 1'b0;
    repeat (50) @(negedge clk);
    check("commit_merge", ack_total - ack0, 64'd1);

    // Transmitter busy beyond the period.
    busy_len = 400;
    wait_start(2 * Period, t, ok);
    k_ov = 0; n_ov = 0; k_st = 0;
    for (int k = 1; k <= 450; k++) begin
      @(negedge clk);
      if (overrun_o) begin n_ov++; if (k_ov == 0) k_ov = k; end
      if (tx_start_o && k_st == 0) k_st = k;
      if (k == 350) busy_len = 10;
    end
    check("overrun_cycle", k_ov, 64'd300);
    check("overrun_count", n_ov, 64'd1);
    check("start_after_overrun", k_st, 64'd403);

    // Transmitter never answers.
    tx_on = 1'b0;
    wait_start(2 * Period, t, ok);
    k_ft = 0; n_ft = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (tx_fault_o) begin n_ft++; if (k_ft == 0) k_ft = k; end
    end
    check("tx_fault_cycle", k_ft, 64'd17);
    check("tx_fault_count", n_ft, 64'd1);
    @(posedge clk); #1 enable = 1'b0;
    tx_on = 1'b1;
    repeat (50) @(negedge clk);

    // Asynchronous reset mid-frame with a commit pending.
    @(posedge clk); #1 enable = 1'b1; busy_len = 100;
    wait_start(2 * Period, t, ok);
    repeat (10) @(negedge clk);
    @(posedge clk); #1 commit_req = 1'b1;
    @(posedge clk); #1 commit_req = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", out_vec(), 64'd0);
    ack0 = ack_total;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("no_ack_after_reset", ack_total - ack0, 64'd0);
    check("post_reset_idle", {rd_bank_o, frame_count_o, tx_num_bytes_o}, 64'd0);

    // Commit while idle and disabled swaps on the next cycle.
    exp_rd_bank = 1'b0;
    @(posedge clk); #1 commit_req = 1'b1;
    @(negedge clk);
    check("idle_ack_early", commit_ack_o, 64'd0);
    @(posedge clk); #1 commit_req = 1'b0;
    @(negedge clk);
    check("idle_commit_ack", commit_ack_o, 64'd1);
    @(negedge clk);
    check("idle_ack_single", commit_ack_o, 64'd0);
    check("idle_rd_bank", rd_bank_o, 64'd1);
    repeat (20) @(negedge clk);
    check("idle_no_frame", frame_count_o, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
